// File: rtl/if_pkg.sv
// ============================================================================
//  Module   : if_pkg
//  Purpose  : Shared definitions for the instruction-fetch stage: datapath
//             width, fetch-state encoding, default reset PC / bubble word and
//             a word-alignment helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    // Instruction / address width
    localparam int INSTR_W = 32;

    // Fetch state encoding
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_REQ  = 2'd0;  // request outstanding or about to issue
    localparam logic [STATE_W-1:0] S_KILL = 2'd1;  // request outstanding, its data is doomed
    localparam logic [STATE_W-1:0] S_FULL = 2'd2;  // word held for a frozen IF/ID

    // Defaults for the fetch-stage parameters
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // Clear the byte-offset bits of an address
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage : if_pkg

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
//  Module   : if_fetch_stage
//  Purpose  : Instruction-fetch stage feeding the IF/ID pipeline register.
//             Owns the PC, drives a req/ack instruction-memory port, holds a
//             fetched word while IF/ID is frozen and follows EXE redirects,
//             including redirects arriving with a request still outstanding.
//  Ports    :
//    clk          in   1   rising-edge clock
//    rst          in   1   asynchronous reset, active-low
//    freeze       in   1   hazard stall, IF/ID does not latch this cycle
//    branch_taken in   1   redirect request from EXE
//    branch_addr  in  32   redirect target (bits [1:0] ignored)
//    imem_req     out  1   fetch request
//    imem_addr    out 32   fetch address, stable until acked
//    imem_ack     in   1   read data valid (may coincide with imem_req)
//    imem_rdata   in  32   instruction word, valid with imem_ack
//    pc           out 32   fetched address + 4, 0 on a bubble
//    instruction  out 32   fetched word, NOP_INSTR on a bubble
//    fetch_valid  out  1   pc/instruction carry a real instruction
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [INSTR_W-1:0] branch_addr,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               fetch_valid
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] r_state;
    logic [INSTR_W-1:0] r_pc;
    logic [INSTR_W-1:0] r_tgt;
    logic [INSTR_W-1:0] r_buf_instr;
    logic [INSTR_W-1:0] r_buf_pc;

    logic [STATE_W-1:0] w_state_nxt;
    logic [INSTR_W-1:0] w_pc_nxt;
    logic [INSTR_W-1:0] w_tgt_nxt;
    logic [INSTR_W-1:0] w_buf_instr_nxt;
    logic [INSTR_W-1:0] w_buf_pc_nxt;

    logic [INSTR_W-1:0] w_pc_plus4;
    logic [INSTR_W-1:0] w_branch_tgt;

    assign w_pc_plus4   = r_pc + 32'd4;             // wraps modulo 2^32
    assign w_branch_tgt = word_align(branch_addr);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_tgt       <= '0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_tgt       <= w_tgt_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_tgt_nxt       = r_tgt;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;

        case (r_state)
            S_KILL: begin
                // The outstanding request must complete before the redirect
                // is followed; the newest redirect target always wins.
                if (branch_taken) begin
                    w_tgt_nxt = w_branch_tgt;
                end
                if (imem_ack) begin
                    w_pc_nxt    = branch_taken ? w_branch_tgt : r_tgt;
                    w_state_nxt = S_REQ;
                end
            end

            S_FULL: begin
                // Redirect drops the held word even if IF/ID is still frozen.
                if (branch_taken) begin
                    w_pc_nxt    = w_branch_tgt;
                    w_state_nxt = S_REQ;
                end else if (!freeze) begin
                    w_state_nxt = S_REQ;
                end
            end

            default: begin
                // S_REQ, and any unused encoding recovers as S_REQ.
                w_state_nxt = S_REQ;
                if (imem_ack) begin
                    if (branch_taken) begin
                        w_pc_nxt = w_branch_tgt;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                        if (freeze) begin
                            // IF/ID ignores the bypassed word; keep it until unfrozen.
                            w_buf_instr_nxt = imem_rdata;
                            w_buf_pc_nxt    = w_pc_plus4;
                            w_state_nxt     = S_FULL;
                        end
                    end
                end else if (branch_taken) begin
                    // Address must stay stable until the ack, so park the target.
                    w_tgt_nxt   = w_branch_tgt;
                    w_state_nxt = S_KILL;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (forced idle/bubble while reset is asserted so imem_req
    // drops without waiting for a clock edge)
    // ------------------------------------------------------------------
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = '0;
        fetch_valid = 1'b0;
        pc          = '0;
        instruction = NOP_INSTR;

        if (rst) begin
            case (r_state)
                S_FULL: begin
                    fetch_valid = 1'b1;
                    pc          = r_buf_pc;
                    instruction = r_buf_instr;
                end

                S_KILL: begin
                    imem_req  = 1'b1;
                    imem_addr = word_align(r_pc);
                end

                default: begin
                    imem_req  = 1'b1;
                    imem_addr = word_align(r_pc);
                    // Zero-wait bypass: the acked word goes straight out.
                    if (imem_ack && !branch_taken) begin
                        fetch_valid = 1'b1;
                        pc          = w_pc_plus4;
                        instruction = imem_rdata;
                    end
                end
            endcase
        end
    end

endmodule : if_fetch_stage

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Purpose  : Self-checking bench for if_fetch_stage. A transaction-level
//             model (next fetch address, held word, pending redirect) predicts
//             every output each cycle; directed scenarios add literal checks.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY         = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        fetch_valid;

    if_fetch_stage #(
        .RESET_PC  (TB_RESET_PC),
        .NOP_INSTR (TB_NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .instruction  (instruction),
        .fetch_valid  (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: where the next fetch goes, a word held for a frozen IF/ID,
    // and whether the outstanding request is to be thrown away.
    logic [31:0] m_addr;
    logic        m_hold;
    logic [31:0] m_hold_pc;
    logic [31:0] m_hold_word;
    logic        m_doomed;
    logic [31:0] m_redirect;

    // Samples of the last compared cycle
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr      = TB_RESET_PC;
        m_hold      = 1'b0;
        m_hold_pc   = '0;
        m_hold_word = '0;
        m_doomed    = 1'b0;
        m_redirect  = '0;
    endtask

    // Compare all DUT outputs against the model for the current cycle.
    task automatic compare_cycle();
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        if (m_hold) begin
            e_req   = 1'b0;
            e_addr  = '0;
            e_valid = 1'b1;
            e_pc    = m_hold_pc;
            e_instr = m_hold_word;
        end else begin
            e_req  = 1'b1;
            e_addr = m_addr;
            if (imem_ack && !branch_taken && !m_doomed) begin
                e_valid = 1'b1;
                e_pc    = m_addr + 32'd4;
                e_instr = m_addr ^ KEY;
            end else begin
                e_valid = 1'b0;
                e_pc    = '0;
                e_instr = TB_NOP;
            end
        end
        s_req   = imem_req;
        s_valid = fetch_valid;
        s_addr  = imem_addr;
        s_pc    = pc;
        s_instr = instruction;
        chk("imem_req",    {31'd0, imem_req},    {31'd0, e_req});
        chk("imem_addr",   imem_addr,            e_addr);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e_valid});
        chk("pc",          pc,                   e_pc);
        chk("instruction", instruction,          e_instr);
    endtask

    // Advance the model by the clock edge that ends the current cycle.
    task automatic model_advance();
        logic [31:0] bt;
        bt = {branch_addr[31:2], 2'b00};
        if (m_hold) begin
            if (branch_taken) begin
                m_hold = 1'b0;
                m_addr = bt;
            end else if (!freeze) begin
                m_hold = 1'b0;
            end
        end else if (m_doomed) begin
            if (imem_ack) begin
                m_addr   = branch_taken ? bt : m_redirect;
                m_doomed = 1'b0;
            end else if (branch_taken) begin
                m_redirect = bt;
            end
        end else if (imem_ack) begin
            if (branch_taken) begin
                m_addr = bt;
            end else begin
                if (freeze) begin
                    m_hold      = 1'b1;
                    m_hold_pc   = m_addr + 32'd4;
                    m_hold_word = m_addr ^ KEY;
                end
                m_addr = m_addr + 32'd4;
            end
        end else if (branch_taken) begin
            m_doomed   = 1'b1;
            m_redirect = bt;
        end
    endtask

    // One clock cycle: drive inputs after the edge, compare at the falling edge.
    task automatic step(input logic f, input logic b, input logic [31:0] ba, input logic want_ack);
        @(posedge clk);
        #1;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        imem_ack     = imem_req & want_ack;
        imem_rdata   = imem_ack ? (imem_addr ^ KEY) : $urandom;
        @(negedge clk);
        compare_cycle();
        model_advance();
    endtask

    initial begin
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        model_reset();

        // Reset state
        #3;
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_pc",    pc,                   32'd0);
        chk("rst_instr", instruction,          TB_NOP);
        @(posedge clk);
        #1 rst = 1'b1;

        // Zero-wait stream
        step(0, 0, 0, 1);
        chk("zw_addr0",  s_addr,  32'h0);
        chk("zw_pc0",    s_pc,    32'h4);
        chk("zw_instr0", s_instr, 32'hA5A5_0000);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("zw_addr2", s_addr, 32'h8);
        chk("zw_pc2",   s_pc,   32'hC);
        step(0, 0, 0, 1);

        // Freeze on the ack of 0x10
        step(1, 0, 0, 1);
        chk("fz_pc_ack", s_pc, 32'h14);
        step(1, 0, 0, 1);
        chk("fz_req_full", {31'd0, s_req}, 32'd0);
        chk("fz_pc_hold",  s_pc,           32'h14);
        chk("fz_instr",    s_instr,        32'hA5A5_0010);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("fz_valid_drop", {31'd0, s_valid}, 32'd1);

        // Two wait states per fetch
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            chk("ws_bubble", {31'd0, s_valid}, 32'd0);
            step(0, 0, 0, 0);
            step(0, 0, 0, 1);
            chk("ws_addr", s_addr, 32'h14 + 32'(4 * k));
            chk("ws_pc",   s_pc,   32'h18 + 32'(4 * k));
        end

        // Branch while waiting on 0x20
        step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0104, 0);
        step(0, 0, 0, 0);
        chk("bw_addr_held", s_addr, 32'h20);
        step(0, 0, 0, 1);
        chk("bw_discard", {31'd0, s_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("bw_new_addr", s_addr, 32'h104);

        // Branch in S_FULL with freeze held
        step(1, 0, 0, 1);
        step(1, 1, 32'h0000_0200, 0);
        step(0, 0, 0, 0);
        chk("bf_addr",  s_addr,           32'h200);
        chk("bf_valid", {31'd0, s_valid}, 32'd0);
        step(0, 0, 0, 1);
        chk("bf_pc", s_pc, 32'h204);

        // Redirect to the top of memory (low bits masked) and wrap
        step(0, 1, 32'hFFFF_FFFF, 1);
        step(0, 0, 0, 1);
        chk("wrap_addr",  s_addr,  32'hFFFF_FFFC);
        chk("wrap_pc",    s_pc,    32'h0);
        chk("wrap_instr", s_instr, 32'h5A5A_FFFC);

        // Reset while a killed request is outstanding
        step(0, 1, 32'h0000_0300, 0);
        @(posedge clk);
        #1;
        chk("kill_req_before", {31'd0, imem_req}, 32'd1);
        #1;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        rst          = 1'b0;
        #1;
        chk("arst_req",   {31'd0, imem_req},    32'd0);
        chk("arst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("arst_tgt",   dut.r_tgt,            32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        step(0, 0, 0, 0);
        chk("arst_addr", s_addr, TB_RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_fetch_stage

`default_nettype wire
